jk_excitation_counter: RTL and testbench
========================================

// Module: jk_excitation_counter
// PURPOSE
//  Synchronous modulo-N up/down counter whose state bits are held in JK flip-flops.
//  The next state is computed in binary and then converted to J/K drive through the JK excitation table.
//  This is the inverse of the JK characteristic equation, going from (Q, Q+) to (J, K).
//  Serves as the counter building block for later sequential exercises.
//  Exposes the per-bit J/K drive so benches can check excitation directly.
// PARAMETERS
//  WIDTH    4   state width in bits; WIDTH >= 1
//  MODULUS  10  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk       in   1      rising-edge clock, the only clock
//  rst       in   1      synchronous reset, active-high
//  en        in   1      count enable
//  up        in   1      direction: 1 = increment, 0 = decrement
//  load      in   1      synchronous parallel load
//  load_val  in   WIDTH  value taken when load=1
//  count     out  WIDTH  current state (Q of the JK cells)
//  tc        out  1      terminal count, combinational
//  j_vec     out  WIDTH  J drive per bit, combinational
//  k_vec     out  WIDTH  K drive per bit, combinational
// BEHAVIOUR
//  - Priority at each rising clk edge: rst > load > en > hold.
//  - rst=1: count <= 0 on the next edge; the JK cell's reset overrides J/K.
//  - rst=1 in the middle of counting: the state is discarded and counting resumes from 0 on the cycle after rst drops.
//  - load=1: count <= load_val. If load_val >= MODULUS, count <= 0 instead.
//  - en=1, up=1: count <= (count == MODULUS-1) ? 0 : count+1.
//  - en=1, up=0: count <= (count == 0) ? MODULUS-1 : count-1.
//  - en=0 and load=0: count holds.
//  - Robustness: any count >= MODULUS goes to 0 on the next enabled step.
//  - Latency: 1 cycle from input to count; tc, j_vec and k_vec have 0-cycle latency.
//  - Next-state vector N is computed by the rules above. Per bit i, the excitation is fixed as:
//      j_vec[i] = ~count[i] &  N[i]   (set)
//      k_vec[i] =  count[i] & ~N[i]   (reset)
//    Equal bits give J=K=0 (hold). The JK toggle code (1,1) is never generated; an assertion checks this.
//  - j_vec and k_vec follow the excitation logic even while rst=1.
//  - tc = en & ~load & ((up & count == MODULUS-1) | (~up & count == 0)).
//  - Simultaneous load and en: load wins and tc is 0.
//  - Reset values: count = 0. tc = 0 unless en & ~up. j_vec and k_vec are the excitation for count = 0.
//  - Arithmetic: unsigned, WIDTH bits. No overflow path exists, because wrap is explicit at MODULUS-1 and 0.
// STRUCTURE
//  - Shared package: JK excitation code constants (HOLD = 2'b00, RESET = 2'b01, SET = 2'b10, TOGGLE = 2'b11).
//  - Same package: a function mapping (q, q_next) to {j, k}, so bench and RTL share one definition.
//  - Sub-module jk_cell: one JK flip-flop with synchronous active-high reset, ports clk, rst, j, k, q, qb.
//    Its next state is q+ = (j & ~q) | (~k & q). It is instantiated WIDTH times with a generate loop.
//  - Top level: the next-state mux (load / up / down / hold / wrap) plus the excitation encoder.
// TESTING
//  - Reset: rst=1 for 2 cycles with en=1, up=1 -> count=0. On release, count steps 1, 2, 3 on the following edges.
//  - Up wrap (MODULUS=10): count=9, en=1, up=1 -> tc=1, j_vec=4'b0000, k_vec=4'b1001. Next cycle count=0.
//  - Down wrap: count=0, en=1, up=0 -> tc=1, j_vec=4'b1001, k_vec=4'b0000. Next cycle count=9.
//  - Load: load=1, load_val=6 with en=1 -> count=6 next cycle and tc=0. A load of 12 -> count=0.
//  - Hold and excitation: en=0 at count=5 for 3 cycles -> count stays 5 and j_vec = k_vec = 0 every cycle.
//  - Mid-run reset and scoreboard: 200 random cycles of en/up/load against a reference model.
//    Assert count < MODULUS and (j_vec & k_vec) == 0 on every cycle.
//    Assert rst for 1 cycle mid-run -> count=0.

Source files
------------

// File: rtl/jk_excitation_counter_pkg.sv
// Shared JK flip-flop definitions: excitation codes, characteristic and excitation functions.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package jk_excitation_counter_pkg;

    // J/K drive codes, packed as {j, k}
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_code_e;

    // Characteristic equation: next Q from current Q and J/K drive
    function automatic logic jk_char(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

    // Excitation table: the {j, k} that moves q to q_next. Toggle is never chosen;
    // a 0->1 move uses SET and a 1->0 move uses RESET, so J and K are never both high.
    function automatic logic [1:0] jk_excite(input logic q, input logic q_next);
        logic [1:0] code;
        code = JK_HOLD;
        case ({q, q_next})
            2'b01:   code = JK_SET;
            2'b10:   code = JK_RESET;
            default: code = JK_HOLD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jk_excitation_counter_cell.sv
// Single JK flip-flop with synchronous active-high reset and complementary outputs.
// Latency: 1 cycle from j/k to q; reset takes effect on the next rising edge.
// Backpressure: none, the cell updates on every edge.
module jk_cell
    import jk_excitation_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_q;
    logic q_d;

    // Next state from the JK characteristic equation
    always_comb begin
        q_d = jk_char(q_q, j, k);
    end

    // State register; reset overrides whatever J/K are driving
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/jk_excitation_counter.sv
// Modulo-MODULUS up/down counter with load, built from WIDTH JK cells driven by excitation logic.
// Latency: 1 cycle inputs to count; tc, j_vec, k_vec are combinational (0 cycles).
// Backpressure: none, every enabled or load cycle takes effect on the next edge.
module jk_excitation_counter
    import jk_excitation_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    // One extra bit so MODULUS == 2**WIDTH is representable for range checks
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;   // Q outputs of the JK cells
    logic [WIDTH-1:0] cell_qb;   // complementary rails of the JK cells
    logic [WIDTH-1:0] count_d;   // binary next state, ignoring rst
    logic             in_range;
    logic             at_top;
    logic             at_zero;
    logic             load_ok;

    // State decode shared by the next-state mux and terminal count
    always_comb begin
        in_range = ({1'b0, count_q} < MOD_EXT);
        at_top   = (count_q == TOP_VAL);
        at_zero  = (count_q == '0);
        load_ok  = ({1'b0, load_val} < MOD_EXT);
    end

    // Next-state mux: load beats count, out-of-range states fall back to 0.
    // rst is handled inside the cells so the excitation stays visible during reset.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_ok ? load_val : '0;
        end else if (en) begin
            if (!in_range) begin
                count_d = '0;
            end else if (up) begin
                count_d = at_top ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = at_zero ? TOP_VAL : count_q - WIDTH'(1);
            end
        end
    end

    // Excitation encoder: per bit, J/K that move current Q to the next state
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_vec[i], k_vec[i]} = jk_excite(count_q[i], count_d[i]);
        end
    end

    // Terminal count: the step about to wrap; suppressed by a pending load
    always_comb begin
        tc = en & ~load & ((up & at_top) | (~up & at_zero));
    end

    // One JK cell per state bit
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_vec[g]),
            .k   (k_vec[g]),
            .q   (count_q[g]),
            .qb  (cell_qb[g])
        );
    end

    assign count = count_q;

    // The toggle code must never reach a cell
    a_no_toggle : assert property (@(posedge clk) (j_vec & k_vec) == '0);

    // Cell rails must stay complementary
    a_rails : assert property (@(posedge clk) cell_qb == ~count_q);

endmodule

// File: tb/tb_jk_excitation_counter.sv
module tb_jk_excitation_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc;
    logic [W-1:0] j_vec;
    logic [W-1:0] k_vec;

    typedef struct {
        logic [W-1:0] cnt;
        logic         tc;
        logic [W-1:0] j;
        logic [W-1:0] k;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    jk_excitation_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .j_vec    (j_vec),
        .k_vec    (k_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and post the outputs expected during that cycle
    task automatic vec(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lv, input logic [W-1:0] ec, input logic et,
                       input logic [W-1:0] ej, input logic [W-1:0] ek);
        exp_t x;
        rst = r; en = e; up = u; load = l; load_val = lv;
        x.cnt = ec; x.tc = et; x.j = ej; x.k = ek;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Reference next state (excluding rst)
    function automatic logic [W-1:0] model_next(input logic [W-1:0] c, input logic e,
                                                input logic u, input logic l,
                                                input logic [W-1:0] lv);
        int ci;
        int li;
        ci = int'(c);
        li = int'(lv);
        if (l) return (li >= M) ? '0 : lv;
        if (!e) return c;
        if (ci >= M) return '0;
        if (u) return (ci == M - 1) ? '0 : W'(ci + 1);
        return (ci == 0) ? W'(M - 1) : W'(ci - 1);
    endfunction

    // Monitor: compare DUT outputs with the oldest expectation, mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("count", count, e.cnt);
            chk("tc", {{(W-1){1'b0}}, tc}, {{(W-1){1'b0}}, e.tc});
            chk("j_vec", j_vec, e.j);
            chk("k_vec", k_vec, e.k);
            chk("count_in_range", {{(W-1){1'b0}}, (int'(count) < M)}, 4'b0001);
            chk("no_toggle", j_vec & k_vec, 4'b0000);
        end
    end

    initial begin
        logic [W-1:0] mc;
        logic [W-1:0] nx;
        logic         r, e, u, l, t;
        logic [W-1:0] lv;
        int           wait_cyc;

        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
        @(posedge clk);
        #1;

        //  rst en up ld lv     count  tc  j        k
        vec(1, 1, 1, 0, 4'd0, 4'd0, 0, 4'b0001, 4'b0000); // second reset cycle
        vec(0, 1, 1, 0, 4'd0, 4'd0, 0, 4'b0001, 4'b0000);
        vec(0, 1, 1, 0, 4'd0, 4'd1, 0, 4'b0010, 4'b0001);
        vec(0, 1, 1, 0, 4'd0, 4'd2, 0, 4'b0001, 4'b0000);
        vec(0, 1, 1, 0, 4'd0, 4'd3, 0, 4'b0100, 4'b0011);
        vec(0, 1, 1, 1, 4'd9, 4'd4, 0, 4'b1001, 4'b0100); // load 9
        vec(0, 1, 1, 0, 4'd0, 4'd9, 1, 4'b0000, 4'b1001); // up wrap
        vec(0, 1, 0, 0, 4'd0, 4'd0, 1, 4'b1001, 4'b0000); // down wrap
        vec(0, 1, 0, 0, 4'd0, 4'd9, 0, 4'b0000, 4'b0001);
        vec(0, 1, 1, 1, 4'd6, 4'd8, 0, 4'b0110, 4'b1000); // load 6 with en
        vec(0, 1, 0, 1, 4'd12, 4'd6, 0, 4'b0000, 4'b0110); // load 12 -> 0
        vec(0, 1, 0, 1, 4'd5, 4'd0, 0, 4'b0101, 4'b0000); // load masks tc at 0
        vec(0, 0, 1, 0, 4'd0, 4'd5, 0, 4'b0000, 4'b0000); // hold x3
        vec(0, 0, 1, 0, 4'd0, 4'd5, 0, 4'b0000, 4'b0000);
        vec(0, 0, 1, 0, 4'd0, 4'd5, 0, 4'b0000, 4'b0000);
        vec(1, 1, 1, 0, 4'd0, 4'd5, 0, 4'b0010, 4'b0001); // mid-run reset
        vec(0, 1, 1, 0, 4'd0, 4'd0, 0, 4'b0001, 4'b0000);
        vec(1, 1, 0, 0, 4'd0, 4'd1, 0, 4'b0000, 4'b0001);
        vec(1, 1, 0, 0, 4'd0, 4'd0, 1, 4'b1001, 4'b0000); // tc during reset, en & ~up
        vec(0, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 4'b0000);

        // Random phase against the reference model, with a forced reset at 100
        mc = 4'd0;
        for (int i = 0; i < 200; i++) begin
            r  = (i == 100) || ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1) == 1;
            lv = W'($urandom_range(0, 15));
            nx = model_next(mc, e, u, l, lv);
            t  = e & ~l & ((u & (int'(mc) == M - 1)) | (~u & (mc == '0)));
            vec(r, e, u, l, lv, mc, t, ~mc & nx, mc & ~nx);
            mc = r ? '0 : nx;
        end

        rst = 1'b0; en = 1'b0; load = 1'b0;
        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        chk("scoreboard_drained", W'(sb_q.size()), 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
